traffic_light_controller: RTL and testbench

TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

---
 rtl/traffic_light_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_traffic_light_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_controller.sv
// Highway / farm-road traffic light controller.
// Drives two lamps from an external long/short timer pair, with a watchdog that
// catches a stuck timer and a flashing-yellow fault mode that only reset can leave.
module traffic_light_controller #(
    parameter int unsigned WD_CYCLES = 8,
    parameter int unsigned FLASH_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_car_farm,
    input  logic       i_long_timer,
    input  logic       i_short_timer,
    output logic       o_Long_time,
    output logic       o_Short_time,
    output logic [1:0] o_hwy_light,
    output logic [1:0] o_farm_light,
    output logic [2:0] o_state,
    output logic       o_fault
);

    localparam int unsigned WdW = $clog2(WD_CYCLES + 1);
    localparam int unsigned FlW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    localparam logic [1:0] LampRed    = 2'b00;
    localparam logic [1:0] LampYellow = 2'b01;
    localparam logic [1:0] LampGreen  = 2'b10;
    localparam logic [1:0] LampDark   = 2'b11;

    typedef enum logic [2:0] {
        StHg    = 3'd0,
        StHy    = 3'd1,
        StAr1   = 3'd2,
        StFg    = 3'd3,
        StFy    = 3'd4,
        StAr2   = 3'd5,
        StFault = 3'd7
    } state_e;

    state_e         state_q, state_d;
    logic           min_done_q, min_done_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic [FlW-1:0] flash_cnt_q, flash_cnt_d;
    logic           flash_dark_q, flash_dark_d;
    logic           prev_long_q, prev_short_q;

    logic [1:0]     hwy_d, farm_d;
    logic           long_d, short_d, fault_d;

    logic           use_long, timed, req_act, timer_now, timer_prev;
    logic           expiry, stall, wd_trip;

    // Select the timer that belongs to the current state and detect expiry / stall.
    always_comb begin
        use_long   = (state_q == StHg) || (state_q == StFg);
        timed      = use_long || (state_q == StHy) || (state_q == StFy);
        req_act    = 1'b0;
        if (use_long) begin
            req_act = o_Long_time;
        end else if (timed) begin
            req_act = o_Short_time;
        end
        timer_now  = use_long ? i_long_timer : i_short_timer;
        timer_prev = use_long ? prev_long_q : prev_short_q;
        // Expiry is the busy flag's falling edge while we are asking for that timer.
        expiry     = req_act && timer_prev && !timer_now;
        // A falling edge is not a stall; it restarts the watchdog instead.
        stall      = timed && req_act && !timer_now && !expiry;
        wd_trip    = stall && (wd_q == WdW'(WD_CYCLES - 1));
    end

    // Next-state logic for the light sequence.
    always_comb begin
        state_d    = state_q;
        min_done_d = min_done_q;
        if (wd_trip) begin
            state_d = StFault;
        end else begin
            unique case (state_q)
                StHg: begin
                    if (expiry) begin
                        min_done_d = 1'b1;
                    end
                    if ((min_done_q || expiry) && i_car_farm) begin
                        state_d = StHy;
                    end
                end
                StHy: begin
                    if (expiry) begin
                        state_d = StAr1;
                    end
                end
                StAr1: begin
                    state_d = StFg;
                end
                StFg: begin
                    // Expiry and an empty farm road together still take one step.
                    if (expiry || !i_car_farm) begin
                        state_d = StFy;
                    end
                end
                StFy: begin
                    if (expiry) begin
                        state_d = StAr2;
                    end
                end
                StAr2: begin
                    state_d    = StHg;
                    min_done_d = 1'b0;
                end
                StFault: begin
                    state_d = StFault;
                end
                default: begin
                    state_d = StFault;
                end
            endcase
        end
    end

    // Watchdog count and fault flash divider.
    always_comb begin
        wd_d = '0;
        if (timed && (state_d == state_q) && stall) begin
            wd_d = wd_q + WdW'(1);
        end

        flash_cnt_d  = '0;
        flash_dark_d = 1'b0;
        if ((state_q == StFault) && (state_d == StFault)) begin
            if (flash_cnt_q == FlW'(FLASH_DIV - 1)) begin
                flash_cnt_d  = '0;
                flash_dark_d = !flash_dark_q;
            end else begin
                flash_cnt_d  = flash_cnt_q + FlW'(1);
                flash_dark_d = flash_dark_q;
            end
        end
    end

    // Output decode from the next state so the output flops line up with the state.
    always_comb begin
        hwy_d   = LampRed;
        farm_d  = LampRed;
        long_d  = 1'b0;
        short_d = 1'b0;
        fault_d = 1'b0;
        unique case (state_d)
            StHg: begin
                hwy_d  = LampGreen;
                long_d = 1'b1;
            end
            StHy: begin
                hwy_d   = LampYellow;
                short_d = 1'b1;
            end
            StAr1, StAr2: begin
                hwy_d  = LampRed;
                farm_d = LampRed;
            end
            StFg: begin
                farm_d = LampGreen;
                long_d = 1'b1;
            end
            StFy: begin
                farm_d  = LampYellow;
                short_d = 1'b1;
            end
            StFault: begin
                hwy_d   = flash_dark_d ? LampDark : LampYellow;
                farm_d  = flash_dark_d ? LampDark : LampYellow;
                fault_d = 1'b1;
            end
            default: begin
                hwy_d  = LampRed;
                farm_d = LampRed;
            end
        endcase
    end

    // State, timer history and registered outputs; synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q      <= StHg;
            min_done_q   <= 1'b0;
            wd_q         <= '0;
            flash_cnt_q  <= '0;
            flash_dark_q <= 1'b0;
            prev_long_q  <= 1'b0;
            prev_short_q <= 1'b0;
            o_hwy_light  <= LampGreen;
            o_farm_light <= LampRed;
            o_state      <= 3'd0;
            o_Long_time  <= 1'b0;
            o_Short_time <= 1'b0;
            o_fault      <= 1'b0;
        end else begin
            state_q      <= state_d;
            min_done_q   <= min_done_d;
            wd_q         <= wd_d;
            flash_cnt_q  <= flash_cnt_d;
            flash_dark_q <= flash_dark_d;
            // A fresh state must not see a stale falling edge from the previous one.
            if (state_d != state_q) begin
                prev_long_q  <= 1'b0;
                prev_short_q <= 1'b0;
            end else begin
                prev_long_q  <= i_long_timer;
                prev_short_q <= i_short_timer;
            end
            o_hwy_light  <= hwy_d;
            o_farm_light <= farm_d;
            o_state      <= state_d;
            o_Long_time  <= long_d;
            o_Short_time <= short_d;
            o_fault      <= fault_d;
        end
    end

    // Timer requests are never raised together.
    assert property (@(posedge i_clk) !(o_Long_time && o_Short_time));

    // The fault flag mirrors the fault state code.
    assert property (@(posedge i_clk) o_fault == (o_state == 3'd7));

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller: a per-cycle vector table plus
// hand-written sequences driven by a small long/short timer model.
module tb_traffic_light_controller;

    localparam int LONG_LEN  = 24;
    localparam int SHORT_LEN = 3;

    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_car_farm = 1'b0;
    logic       i_long_timer = 1'b0;
    logic       i_short_timer = 1'b0;
    logic       o_Long_time, o_Short_time, o_fault;
    logic [1:0] o_hwy_light, o_farm_light;
    logic [2:0] o_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit auto_tmr = 1'b0;
    int lcnt = 0;
    int scnt = 0;

    traffic_light_controller #(
        .WD_CYCLES (8),
        .FLASH_DIV (4)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_car_farm    (i_car_farm),
        .i_long_timer  (i_long_timer),
        .i_short_timer (i_short_timer),
        .o_Long_time   (o_Long_time),
        .o_Short_time  (o_Short_time),
        .o_hwy_light   (o_hwy_light),
        .o_farm_light  (o_farm_light),
        .o_state       (o_state),
        .o_fault       (o_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       car;
        logic       lt;
        logic       st;
        logic [9:0] exp_out;
    } vec_t;

    vec_t vecs [20];

    // {state, hwy, farm, long_req, short_req, fault}
    function automatic logic [9:0] ov(input logic [2:0] s, input logic [1:0] h,
                                      input logic [1:0] f, input logic l,
                                      input logic sh, input logic flt);
        return {s, h, f, l, sh, flt};
    endfunction

    function automatic logic [9:0] outs();
        return {o_state, o_hwy_light, o_farm_light, o_Long_time, o_Short_time, o_fault};
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One clock, then let the timer model answer the new requests.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (auto_tmr) begin
            if (!o_Long_time) begin
                lcnt = 0; i_long_timer = 1'b0;
            end else if (lcnt < LONG_LEN) begin
                lcnt++; i_long_timer = 1'b1;
            end else begin
                lcnt = 0; i_long_timer = 1'b0;
            end
            if (!o_Short_time) begin
                scnt = 0; i_short_timer = 1'b0;
            end else if (scnt < SHORT_LEN) begin
                scnt++; i_short_timer = 1'b1;
            end else begin
                scnt = 0; i_short_timer = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        cyc();
        cyc();
        i_reset = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name,
                              output int k);
        k = 0;
        while (o_state !== s && k < budget) begin
            cyc();
            k++;
        end
        chk(name, 16'(o_state), 16'(s));
    endtask

    // Walk HG -> HY -> AR1 -> FG with hand-driven timers.
    task automatic go_fg_manual();
        auto_tmr = 1'b0;
        i_long_timer = 1'b0; i_short_timer = 1'b0; i_car_farm = 1'b1;
        do_reset();
        i_long_timer = 1'b1; cyc();
        i_long_timer = 1'b0; cyc();
        i_short_timer = 1'b1; cyc();
        i_short_timer = 1'b0; cyc();
        cyc();
        chk("manual_fg", 16'(o_state), 16'd3);
    endtask

    initial begin : watchdog_timer
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int k;
        int nexp;
        logic prev_lt;
        logic [1:0] lamp;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, ov(3'd0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0)};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, ov(3'd0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0)};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, ov(3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0)};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, ov(3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0)};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, ov(3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0)};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, ov(3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0)};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, ov(3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0)};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, ov(3'd1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0)};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, ov(3'd1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0)};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, ov(3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0)};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, ov(3'd3, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0)};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, ov(3'd3, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0)};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, ov(3'd3, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0)};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, ov(3'd4, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0)};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, ov(3'd4, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0)};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, ov(3'd5, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0)};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, ov(3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0)};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0, ov(3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0)};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0, ov(3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0)};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b0, ov(3'd1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0)};

        // Vector table: reset, minimum-green memory, full cycle with short timers.
        auto_tmr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            i_reset       = vecs[i].rst;
            i_car_farm    = vecs[i].car;
            i_long_timer  = vecs[i].lt;
            i_short_timer = vecs[i].st;
            cyc();
            chk($sformatf("vec%0d", i), 16'(outs()), 16'(vecs[i].exp_out));
        end

        // Full cycle with a 24-cycle long timer and 3-cycle short timer.
        auto_tmr = 1'b1;
        i_car_farm = 1'b1;
        do_reset();
        wait_state(3'd1, 60, "cyc_reach_hy", k);
        chk("cyc_hy_latency", 16'(k), 16'd26);
        chk("cyc_hy_out", 16'(outs()), 16'(ov(3'd1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0)));
        wait_state(3'd2, 10, "cyc_reach_ar1", k);
        chk("cyc_ar1_out", 16'(outs()), 16'(ov(3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0)));
        cyc();
        chk("cyc_fg_out", 16'(outs()), 16'(ov(3'd3, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0)));
        wait_state(3'd4, 60, "cyc_reach_fy", k);
        chk("cyc_fy_latency", 16'(k), 16'd25);
        chk("cyc_fy_out", 16'(outs()), 16'(ov(3'd4, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0)));
        wait_state(3'd5, 10, "cyc_reach_ar2", k);
        chk("cyc_ar2_out", 16'(outs()), 16'(ov(3'd5, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0)));
        cyc();
        chk("cyc_hg_again", 16'(outs()), 16'(ov(3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0)));

        // No car through two long expiries, then a car arrives.
        i_car_farm = 1'b0;
        do_reset();
        nexp = 0;
        k = 0;
        prev_lt = i_long_timer;
        while (nexp < 2 && k < 100) begin
            cyc();
            k++;
            if (prev_lt && !i_long_timer) nexp++;
            prev_lt = i_long_timer;
        end
        chk("nocar_expiries", 16'(nexp), 16'd2);
        cyc();
        chk("nocar_hold1", 16'(o_state), 16'd0);
        cyc();
        chk("nocar_hold2", 16'(o_state), 16'd0);
        i_car_farm = 1'b1;
        cyc();
        chk("nocar_then_car", 16'(outs()), 16'(ov(3'd1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0)));

        // Farm road empties 5 cycles into FG.
        i_car_farm = 1'b1;
        do_reset();
        wait_state(3'd3, 100, "early_reach_fg", k);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("early_fg_hold%0d", i), 16'(o_state), 16'd3);
        end
        i_car_farm = 1'b0;
        cyc();
        chk("early_fy", 16'(outs()), 16'(ov(3'd4, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0)));

        // Long expiry coinciding with an empty farm road: one step only.
        go_fg_manual();
        i_long_timer = 1'b1; cyc();
        i_long_timer = 1'b0; i_car_farm = 1'b0; cyc();
        chk("dual_fy", 16'(outs()), 16'(ov(3'd4, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0)));
        i_short_timer = 1'b1; cyc();
        chk("dual_no_double", 16'(o_state), 16'd4);
        i_short_timer = 1'b0; cyc();
        chk("dual_ar2", 16'(o_state), 16'd5);
        cyc();
        chk("dual_hg", 16'(o_state), 16'd0);

        // One-cycle reset in the middle of FG.
        go_fg_manual();
        i_long_timer = 1'b1; cyc();
        i_reset = 1'b0; cyc();
        chk("fg_reset", 16'(outs()), 16'(ov(3'd0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0)));
        i_reset = 1'b1; i_long_timer = 1'b0; cyc();
        chk("fg_reset_release", 16'(outs()), 16'(ov(3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0)));

        // Stuck long timer in HG trips the watchdog after 8 stalled cycles.
        auto_tmr = 1'b0;
        i_long_timer = 1'b0; i_short_timer = 1'b0; i_car_farm = 1'b0;
        do_reset();
        cyc();
        chk("wd_start", 16'(outs()), 16'(ov(3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0)));
        for (int i = 0; i < 7; i++) cyc();
        chk("wd_not_yet", 16'(o_state), 16'd0);
        cyc();
        chk("wd_fault", 16'(outs()), 16'(ov(3'd7, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1)));
        for (int i = 1; i < 16; i++) begin
            i_car_farm   = i[0];
            i_long_timer = i[1];
            cyc();
            lamp = ((i / 4) % 2 == 1) ? 2'b11 : 2'b01;
            chk($sformatf("flash%0d", i), 16'(outs()),
                16'(ov(3'd7, lamp, lamp, 1'b0, 1'b0, 1'b1)));
        end
        i_reset = 1'b0; cyc();
        chk("fault_reset", 16'(outs()), 16'(ov(3'd0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0)));
        i_reset = 1'b1; i_long_timer = 1'b1; cyc();
        chk("fault_reset_release", 16'(outs()), 16'(ov(3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
